// File: rtl/data_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared types and constants for the data memory responder.
//   state_e  : responder FSM states (IDLE, WAIT, RESP)
//   RW_LOAD  : req_rw value for a load
//   RW_STORE : req_rw value for a store
// ---------------------------------------------------------------------------
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic RW_LOAD  = 1'b1;
    localparam logic RW_STORE = 1'b0;

    // True when the access type denotes a store.
    function automatic logic is_store(input logic rw);
        return (rw == RW_STORE);
    endfunction

endpackage

// File: rtl/data_mem_responder_dm_array.sv
// ---------------------------------------------------------------------------
// dm_array
// Single-port storage, 2**ADDR_W words of DATA_W bits.
// Synchronous write, registered read; contents are never reset.
// Ports:
//   clk   : clock
//   we    : write enable (writes wdata to addr on the rising edge)
//   re    : read enable (captures mem[addr] into rdata on the rising edge)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, holds until the next read
// ---------------------------------------------------------------------------
module dm_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];
    logic [DATA_W-1:0] rdata_r;

    // Storage write port and read-data register.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Single-outstanding memory responder with WAIT_CYCLES wait states per access.
// Optional feature macro: DATA_MEM_PROTECT_EN -- stores to addresses below
// PROT_LIMIT are dropped and answered with rsp_err=1.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   req_valid/ready   : request handshake (ready only in IDLE)
//   req_rw            : 1 = load, 0 = store
//   req_addr/wdata    : word address and store data
//   rsp_valid/ready   : response handshake
//   rsp_rdata         : load data, 0 for stores
//   rsp_err           : protection error (always 0 without the macro)
// ---------------------------------------------------------------------------
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 12,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] PROT_LIMIT  = 12'h010
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

`ifdef DATA_MEM_PROTECT_EN
    localparam logic PROT_EN = 1'b1;
`else
    localparam logic PROT_EN = 1'b0;
`endif

    state_e            state_r;
    logic [3:0]        cnt_r;
    logic              rw_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              req_ready_r;
    logic              rsp_valid_r;
    logic              rsp_load_r;
    logic              rsp_err_r;

    logic              accept_s;
    logic              access_s;
    logic              acc_rw_s;
    logic [ADDR_W-1:0] acc_addr_s;
    logic [DATA_W-1:0] acc_wdata_s;
    logic              prot_hit_s;
    logic              we_s;
    logic              re_s;
    logic [DATA_W-1:0] rd_data_s;

    // Access decode: with zero wait states the access happens on the
    // acceptance edge, so the array must see the live request inputs there;
    // otherwise it uses the values captured at acceptance.
    always_comb begin
        accept_s = (state_r == IDLE) && req_ready_r && req_valid;
        if (state_r == IDLE) begin
            acc_rw_s    = req_rw;
            acc_addr_s  = req_addr;
            acc_wdata_s = req_wdata;
        end else begin
            acc_rw_s    = rw_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
        end
        if (WAIT_CYCLES == 0) begin
            access_s = accept_s;
        end else begin
            access_s = (state_r == WAIT) && (cnt_r == 4'd1);
        end
        prot_hit_s = PROT_EN && is_store(acc_rw_s) && (acc_addr_s < PROT_LIMIT);
        we_s       = access_s && is_store(acc_rw_s) && !prot_hit_s;
        re_s       = access_s && !is_store(acc_rw_s);
    end

    dm_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dm_array (
        .clk   (clk),
        .we    (we_s),
        .re    (re_s),
        .addr  (acc_addr_s),
        .wdata (acc_wdata_s),
        .rdata (rd_data_s)
    );

    // Responder FSM, wait counter, request capture and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            rw_r        <= RW_STORE;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_load_r  <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        rw_r        <= req_rw;
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        req_ready_r <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_load_r  <= !is_store(req_rw);
                            rsp_err_r   <= prot_hit_s;
                        end else begin
                            cnt_r   <= WAIT_LD;
                            state_r <= WAIT;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_load_r  <= !is_store(rw_r);
                        rsp_err_r   <= prot_hit_s;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= 4'd0;
                    req_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    // The read register only updates on a load access, so it holds steady
    // for the whole response; stores present zero.
    assign rsp_rdata = rsp_load_r ? rd_data_s : {DATA_W{1'b0}};

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Scoreboard bench: one responder with default wait states, one with zero.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

`ifdef DATA_MEM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        logic        known;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, req_rw, rsp_valid, rsp_ready, rsp_err;
    logic [11:0] req_addr;
    logic [15:0] req_wdata, rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_rw, z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [11:0] z_req_addr;
    logic [15:0] z_req_wdata, z_rsp_rdata;

    int          n_vec  = 0;
    int          n_miss = 0;
    exp_t        sb[$];
    exp_t        sb0[$];
    logic [15:0] mdl [int];

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_rw(z_req_rw),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected response for an access, updating the reference memory.
    function automatic exp_t predict(input logic rw, input logic [11:0] a, input logic [15:0] d);
        exp_t e;
        if (rw) begin
            e.known = mdl.exists(int'(a));
            e.rdata = e.known ? mdl[int'(a)] : 16'h0000;
            e.err   = 1'b0;
        end else begin
            e.err   = PROT && (a < 12'h010);
            e.rdata = 16'h0000;
            e.known = 1'b1;
            if (!e.err) mdl[int'(a)] = d;
        end
        return e;
    endfunction

    // One access on the default-latency responder; inputs are scrambled the
    // cycle after acceptance, and the response is held for 'hold' cycles.
    task automatic access(input logic rw, input logic [11:0] a, input logic [15:0] d, input int hold);
        int   n;
        int   edges;
        exp_t e;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
        sb.push_back(predict(rw, a, d));
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        req_valid = 1'b0; req_addr = a ^ 12'hFFF; req_wdata = ~d; req_rw = ~rw;
        while (!rsp_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check_eq("latency", 32'(edges), 32'd3);
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            check_eq("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("hold_ready", {31'd0, req_ready}, 32'd0);
            if (e.known) check_eq("hold_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
            req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h123; req_wdata = 16'hDEAD;
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (e.known) check_eq("rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
        check_eq("err", {31'd0, rsp_err}, {31'd0, e.err});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("valid_after_hs", {31'd0, rsp_valid}, 32'd0);
        check_eq("ready_after_hs", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int   issued, got, prev;
        exp_t e;
        reset = 1'b0;
        req_valid = 1'b0; req_rw = 1'b0; req_addr = 12'h000; req_wdata = 16'h0000; rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_rw = 1'b0; z_req_addr = 12'h000; z_req_wdata = 16'h0000; z_rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        check_eq("rst_err", {31'd0, rsp_err}, 32'd0);
        check_eq("rst_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("ready_post_rst", {31'd0, req_ready}, 32'd1);

        // Store then load, boundaries, protection region
        access(1'b0, 12'h100, 16'hBEEF, 0);
        access(1'b1, 12'h100, 16'h0000, 0);
        access(1'b0, 12'h00F, 16'h5555, 0);
        access(1'b1, 12'h00F, 16'h0000, 0);
        access(1'b0, 12'h010, 16'h5555, 0);
        access(1'b1, 12'h010, 16'h0000, 0);
        access(1'b0, 12'hFFF, 16'h1357, 0);
        access(1'b0, 12'h800, 16'hC0DE, 0);
        access(1'b1, 12'hFFF, 16'h0000, 0);
        access(1'b1, 12'h800, 16'h0000, 0);
        // Stalled response with a new request ignored
        access(1'b1, 12'h100, 16'h0000, 5);

        // Reset during WAIT aborts a store
        access(1'b0, 12'h200, 16'hAAAA, 0);
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h200; req_wdata = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("abort_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("abort_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_idle", {31'd0, req_ready}, 32'd1);
        check_eq("abort_valid2", {31'd0, rsp_valid}, 32'd0);
        access(1'b1, 12'h200, 16'h0000, 0);

        // Zero wait states, back-to-back with rsp_ready held high
        z_rsp_ready = 1'b1;
        issued = 0; got = 0; prev = -1;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            if (z_rsp_valid) begin
                check_eq("z_ready_in_resp", {31'd0, z_req_ready}, 32'd0);
                if (sb0.size() > 0) begin
                    e = sb0.pop_front();
                    check_eq("z_rdata", {16'd0, z_rsp_rdata}, {16'd0, e.rdata});
                    check_eq("z_err", {31'd0, z_rsp_err}, {31'd0, e.err});
                end else begin
                    check_eq("z_spurious", 32'd1, 32'd0);
                end
                if (prev >= 0) check_eq("z_spacing", 32'(cyc - prev), 32'd2);
                prev = cyc;
                got++;
            end
            if (z_req_ready) begin
                if (issued < 8) begin
                    z_req_valid = 1'b1;
                    z_req_rw    = (issued >= 4);
                    z_req_addr  = 12'h300 + 12'(issued % 4);
                    z_req_wdata = 16'hA000 + 16'(issued % 4);
                    e.rdata = (issued >= 4) ? z_req_wdata : 16'h0000;
                    e.err   = 1'b0;
                    e.known = 1'b1;
                    sb0.push_back(e);
                    issued++;
                end else begin
                    z_req_valid = 1'b0;
                end
            end
        end
        z_req_valid = 1'b0;
        check_eq("z_count", 32'(got), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the data word width.
REQ-002 SHALL have parameter ADDR_W, default 12, the word address width; storage depth is 2**ADDR_W.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, the wait states inserted per access; legal range 0..15.
REQ-004 SHALL have parameter PROT_LIMIT, default 12'h010; used only under REQ-027.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, the asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1, the initiator's access request.
REQ-008 SHALL have port req_ready, output, 1, high when the block accepts a request.
REQ-009 SHALL have port req_rw, input, 1, the access type: 1 = load, 0 = store.
REQ-010 SHALL have port req_addr, input, ADDR_W, the word address.
REQ-011 SHALL have port req_wdata, input, DATA_W, the store data.
REQ-012 SHALL have port rsp_valid, output, 1, high when a response is presented.
REQ-013 SHALL have port rsp_ready, input, 1, high when the initiator takes the response.
REQ-014 SHALL have port rsp_rdata, output, DATA_W, the load data; 0 for stores.
REQ-015 SHALL have port rsp_err, output, 1, the error flag; constant 0 when DATA_MEM_PROTECT_EN is undefined.

Function
REQ-016 SHALL implement states IDLE, WAIT and RESP.
REQ-017 SHALL drive req_ready = 1 only in IDLE; the request is accepted on the edge where req_valid && req_ready is high.
REQ-018 SHALL register req_rw, req_addr and req_wdata on the acceptance edge; later input changes SHALL have no effect on that access.
REQ-019 Accept with WAIT_CYCLES=0: SHALL perform the access on the acceptance edge and go IDLE->RESP.
REQ-020 Accept with WAIT_CYCLES>0: SHALL load a 4-bit counter with WAIT_CYCLES and go IDLE->WAIT.
REQ-021 In WAIT, the counter SHALL decrement each edge; on the edge where it reads 1, the block SHALL perform the access and go to RESP.
REQ-022 SHALL raise rsp_valid exactly WAIT_CYCLES+1 rising edges after the acceptance edge, counting the acceptance edge as edge 1.
REQ-023 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until the edge where rsp_ready=1; that edge SHALL return the block to IDLE.
REQ-024 SHALL accept a new request no earlier than the cycle after the response handshake; one access is outstanding at most.
REQ-025 A store SHALL write req_wdata to the registered address and respond with rsp_rdata=0; a load SHALL return the stored word, read at the access edge.
REQ-026 Address arithmetic SHALL be exact within ADDR_W; there is no wrap-around or translation.

Configuration
REQ-027 With macro DATA_MEM_PROTECT_EN defined, a store to an address < PROT_LIMIT SHALL leave memory unchanged and respond with rsp_err=1 after normal latency.
REQ-028 With DATA_MEM_PROTECT_EN defined, loads SHALL never set rsp_err.
REQ-029 Without DATA_MEM_PROTECT_EN, all stores SHALL be performed and rsp_err SHALL be tied 0.

Reset
REQ-030 On reset low, the block SHALL asynchronously force state IDLE, counter 0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-031 req_ready SHALL be 0 while reset is low and 1 from the first cycle after release.
REQ-032 Reset asserted in WAIT SHALL abort the access; memory SHALL be unchanged.
REQ-033 Reset SHALL NOT clear the memory contents.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE/WAIT/RESP) and the access-type constants RW_LOAD=1 and RW_STORE=0.
REQ-035 The storage SHALL be one sub-module, dm_array: synchronous write, registered read, 2**ADDR_W x DATA_W.
REQ-036 The FSM, wait counter and response registers SHALL be in data_mem_responder.

Verification
REQ-037 Store 16'hBEEF at addr 12'h100, then load 12'h100 with WAIT_CYCLES=2 -> rsp_rdata=16'hBEEF on edge 3 after acceptance, rsp_err=0.
REQ-038 WAIT_CYCLES=0, back-to-back loads with rsp_ready held 1 -> one response per 2 cycles, req_ready low during RESP.
REQ-039 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0, and a new req_valid ignored throughout.
REQ-040 Reset pulsed low during WAIT of a store of 16'h1234 to 12'h200 -> rsp_valid=0 and IDLE; a later load of 12'h200 returns its prior value.
REQ-041 With DATA_MEM_PROTECT_EN, store 16'h5555 to 12'h00F -> rsp_err=1 and contents unchanged; store to 12'h010 -> rsp_err=0 and written.
REQ-042 Change req_addr and req_wdata the cycle after acceptance -> the access uses the originally captured values.
